// File: rtl/l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// l2_arb_pkg
// Shared types and defaults for the L2 input arbiter.
//   src_t          : encoding of the granted source on out_src
//                    (0=rsp, 1=fwd, 2=flush, 3=cpu).
//   flush_state_t  : flush sequencing states (IDLE, FLUSHING, DRAIN).
//   *_DEF          : default parameter values used by the arbiter.
//   src_onehot()   : maps a source to its one-hot ready bit position.
// ---------------------------------------------------------------------------
package l2_arb_pkg;

  localparam int LINE_ADDR_W_DEF  = 28;
  localparam int STARVE_LIMIT_DEF = 8;
  localparam int STARVE_W_DEF     = 4;

  typedef enum logic [1:0] {
    SRC_RSP   = 2'd0,
    SRC_FWD   = 2'd1,
    SRC_FLUSH = 2'd2,
    SRC_CPU   = 2'd3
  } src_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSHING = 2'd1,
    DRAIN    = 2'd2
  } flush_state_t;

  // Bit order of the result is {cpu, flush, fwd, rsp}.
  function automatic logic [3:0] src_onehot(input src_t s);
    return 4'b0001 << s;
  endfunction

endpackage

// File: rtl/l2_input_arbiter_if.sv
// ---------------------------------------------------------------------------
// l2_input_arbiter_if
// Bundles the inbound channel handshakes, the eligibility side-band inputs
// and the output stage handshake of the L2 input arbiter.
//   slave  : the arbiter's view (channel valid/addr in, ready out,
//            out_* towards the lookup pipeline).
//   master : the surrounding environment's view (opposite directions).
// ---------------------------------------------------------------------------
interface l2_input_arbiter_if #(
  parameter int LINE_ADDR_W = 28
);

  logic                   rsp_in_valid;
  logic [LINE_ADDR_W-1:0] rsp_in_addr;
  logic                   rsp_in_ready;

  logic                   fwd_in_valid;
  logic [LINE_ADDR_W-1:0] fwd_in_addr;
  logic                   fwd_in_ready;

  logic                   cpu_req_valid;
  logic [LINE_ADDR_W-1:0] cpu_req_addr;
  logic                   cpu_req_ready;

  logic                   flush_valid;
  logic                   flush_ready;

  logic                   fwd_stall;
  logic                   mshr_full;
  logic                   flush_done;

  logic                   out_valid;
  logic                   out_ready;
  logic [1:0]             out_src;
  logic [LINE_ADDR_W-1:0] out_addr;
  logic                   flushing;

  modport slave (
    input  rsp_in_valid, rsp_in_addr,
    output rsp_in_ready,
    input  fwd_in_valid, fwd_in_addr,
    output fwd_in_ready,
    input  cpu_req_valid, cpu_req_addr,
    output cpu_req_ready,
    input  flush_valid,
    output flush_ready,
    input  fwd_stall, mshr_full, flush_done,
    output out_valid, out_src, out_addr, flushing,
    input  out_ready
  );

  modport master (
    output rsp_in_valid, rsp_in_addr,
    input  rsp_in_ready,
    output fwd_in_valid, fwd_in_addr,
    input  fwd_in_ready,
    output cpu_req_valid, cpu_req_addr,
    input  cpu_req_ready,
    output flush_valid,
    input  flush_ready,
    output fwd_stall, mshr_full, flush_done,
    input  out_valid, out_src, out_addr, flushing,
    output out_ready
  );

endinterface

// File: rtl/l2_arb_out_stage.sv
// ---------------------------------------------------------------------------
// l2_arb_out_stage
// One-entry valid/ready register between the arbiter and the L2 lookup.
//   clk, rst     : clock, synchronous active-high reset
//   load         : a grant was made this cycle (only asserted when can_load)
//   load_src/addr: source and address of that grant
//   out_ready    : pipeline consumes the held entry
//   out_valid/src/addr : held entry
//   can_load     : stage is empty or being drained this cycle
// A load in the same cycle as a drain overwrites the entry, so a steady
// stream of grants produces one output per cycle with no bubble.
// ---------------------------------------------------------------------------
module l2_arb_out_stage
  import l2_arb_pkg::*;
#(
  parameter int LINE_ADDR_W = LINE_ADDR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  src_t                   load_src,
  input  logic [LINE_ADDR_W-1:0] load_addr,
  input  logic                   out_ready,
  output logic                   out_valid,
  output src_t                   out_src,
  output logic [LINE_ADDR_W-1:0] out_addr,
  output logic                   can_load
);

  logic                   valid_q, valid_d;
  src_t                   src_q, src_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    src_d   = src_q;
    addr_d  = addr_q;
    if (load) begin
      valid_d = 1'b1;
      src_d   = load_src;
      addr_d  = load_addr;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // src/addr only change on a load, which keeps them stable while the
  // entry is stalled by out_ready=0.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      src_q   <= SRC_RSP;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      src_q   <= src_d;
      addr_q  <= addr_d;
    end
  end

  assign can_load  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_src   = src_q;
  assign out_addr  = addr_q;

endmodule

// File: rtl/l2_input_arbiter.sv
// ---------------------------------------------------------------------------
// l2_input_arbiter
// Picks one inbound L2 channel per cycle (response-in, forward-in, flush,
// CPU request) and registers the winner into a one-entry output stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : l2_input_arbiter_if.slave carrying all channel handshakes,
//              fwd_stall / mshr_full / flush_done side-band inputs, the
//              out_valid/out_ready/out_src/out_addr stage and flushing.
// Priority is rsp > fwd > flush > cpu; once a CPU request has lost
// STARVE_LIMIT arbitrations in a row it is boosted to rsp > cpu > fwd >
// flush. Response-in always wins so outstanding misses can retire.
// ---------------------------------------------------------------------------
module l2_input_arbiter
  import l2_arb_pkg::*;
#(
  parameter int LINE_ADDR_W  = LINE_ADDR_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int STARVE_W     = STARVE_W_DEF
) (
  input logic               clk,
  input logic               rst,
  l2_input_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  flush_state_t           state_q, state_d;
  logic [STARVE_W-1:0]    starve_cnt_q, starve_cnt_d;

  logic                   can_load;
  logic                   boost;
  logic                   elig_rsp, elig_fwd, elig_flush, elig_cpu;
  logic                   grant_vld;
  src_t                   grant_src;
  logic [LINE_ADDR_W-1:0] grant_addr;
  logic [3:0]             ready_vec;
  src_t                   stage_src;

  // ---------------------------------------------------------------- eligibility
  assign elig_rsp   = bus.rsp_in_valid;
  assign elig_fwd   = bus.fwd_in_valid && !bus.fwd_stall;
  assign elig_flush = bus.flush_valid && (state_q == IDLE);
  assign elig_cpu   = bus.cpu_req_valid && !bus.mshr_full && (state_q == IDLE);
  assign boost      = (starve_cnt_q == STARVE_MAX);

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    grant_vld  = 1'b0;
    grant_src  = SRC_RSP;
    grant_addr = '0;
    if (!rst && can_load) begin
      if (elig_rsp) begin
        grant_vld  = 1'b1;
        grant_src  = SRC_RSP;
        grant_addr = bus.rsp_in_addr;
      end else if (boost && elig_cpu) begin
        grant_vld  = 1'b1;
        grant_src  = SRC_CPU;
        grant_addr = bus.cpu_req_addr;
      end else if (elig_fwd) begin
        grant_vld  = 1'b1;
        grant_src  = SRC_FWD;
        grant_addr = bus.fwd_in_addr;
      end else if (elig_flush) begin
        // A flush carries no line address.
        grant_vld  = 1'b1;
        grant_src  = SRC_FLUSH;
        grant_addr = '0;
      end else if (elig_cpu) begin
        grant_vld  = 1'b1;
        grant_src  = SRC_CPU;
        grant_addr = bus.cpu_req_addr;
      end
    end
  end

  assign ready_vec         = grant_vld ? src_onehot(grant_src) : 4'b0000;
  assign bus.rsp_in_ready  = ready_vec[SRC_RSP];
  assign bus.fwd_in_ready  = ready_vec[SRC_FWD];
  assign bus.flush_ready   = ready_vec[SRC_FLUSH];
  assign bus.cpu_req_ready = ready_vec[SRC_CPU];

  // ---------------------------------------------------------------- starvation
  // Counts arbitrations an eligible CPU request lost. While the CPU is
  // ineligible (MSHRs full, flush active) or the stage cannot load, the
  // count is frozen rather than cleared so the boost is not forfeited.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.cpu_req_valid) begin
      starve_cnt_d = '0;
    end else if (grant_vld && (grant_src == SRC_CPU)) begin
      starve_cnt_d = '0;
    end else if (elig_cpu && can_load && !boost) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
  end

  // ---------------------------------------------------------------- flush FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (grant_vld && (grant_src == SRC_FLUSH)) state_d = FLUSHING;
      FLUSHING: if (bus.flush_done) state_d = DRAIN;
      DRAIN:    state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign bus.flushing = (state_q != IDLE);

  // ---------------------------------------------------------------- output stage
  l2_arb_out_stage #(
    .LINE_ADDR_W (LINE_ADDR_W)
  ) u_out_stage (
    .clk       (clk),
    .rst       (rst),
    .load      (grant_vld),
    .load_src  (grant_src),
    .load_addr (grant_addr),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_src   (stage_src),
    .out_addr  (bus.out_addr),
    .can_load  (can_load)
  );

  assign bus.out_src = stage_src;

endmodule

// File: doc/l2_input_arbiter.md
Name: l2_input_arbiter

Overview:
- Selects which inbound L2 channel feeds the L2 lookup pipeline each cycle: response-in, forward-in, flush, or CPU request.
- Applies the coherence priority rules and pipeline back-pressure, with a starvation guard for CPU requests and a flush-sequencing FSM.
- Registers the winner into a one-entry output stage that the L2 pipeline drains with a valid/ready handshake.
- Sits between the l2_*_if input interfaces and the L2 tag/state lookup stage.

Parameters:
- LINE_ADDR_W, 28, width of line_addr_t.
- STARVE_LIMIT, 8, consecutive cycles a valid CPU request may lose before it is boosted.
- STARVE_W, 4, width of the starvation counter; must satisfy 2^STARVE_W > STARVE_LIMIT.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active high
- rsp_in_valid  in  1  response-in pending
- rsp_in_addr  in  LINE_ADDR_W  response-in line address
- rsp_in_ready  out  1  response-in accepted this cycle
- fwd_in_valid  in  1  forward-in pending
- fwd_in_addr  in  LINE_ADDR_W  forward-in line address
- fwd_in_ready  out  1  forward-in accepted
- cpu_req_valid  in  1  CPU request pending
- cpu_req_addr  in  LINE_ADDR_W  CPU request line address
- cpu_req_ready  out  1  CPU request accepted
- flush_valid  in  1  flush request pending
- flush_ready  out  1  flush accepted
- fwd_stall  in  1  forward conflicts with an in-flight MSHR; forward is ineligible
- mshr_full  in  1  no free MSHR; CPU request is ineligible
- flush_done  in  1  one-cycle pulse from the pipeline when the flush walk completes
- out_valid  out  1  output stage holds a grant
- out_ready  in  1  pipeline consumes the output stage
- out_src  out  2  0=rsp, 1=fwd, 2=flush, 3=cpu
- out_addr  out  LINE_ADDR_W  address of the granted message (0 for flush)
- flushing  out  1  flush in progress

Behaviour:
- Reset values: out_valid=0, out_src=0, out_addr=0, flushing=0, starvation counter=0, FSM=IDLE. All *_ready outputs are 0 during rst.
- Output stage: can_load = !out_valid || out_ready. Arbitration happens only when can_load=1; at most one *_ready is high per cycle. The winner loads the stage on the same edge, so latency is 1 cycle from accept to out_valid.
- Eligibility:
  - rsp: rsp_in_valid.
  - fwd: fwd_in_valid && !fwd_stall.
  - flush: flush_valid && FSM==IDLE.
  - cpu: cpu_req_valid && !mshr_full && FSM==IDLE.
- Priority: rsp > fwd > flush > cpu. When boost=1, the order is rsp > cpu > fwd > flush. Response-in is never preempted, to guarantee forward progress of outstanding misses.
- Starvation counter:
  - Increments when cpu_req_valid, cpu is eligible, can_load=1 and cpu is not granted.
  - Saturates at STARVE_LIMIT; boost = (counter == STARVE_LIMIT).
  - Clears to 0 on a cpu grant, or when cpu_req_valid=0.
  - Holds while mshr_full=1, FSM!=IDLE, or can_load=0.
- FSM:
  - IDLE: a flush grant moves to FLUSHING.
  - FLUSHING: flushing=1; cpu and flush are ineligible; rsp and fwd are still served. flush_done moves to DRAIN.
  - DRAIN: flushing=1 for one cycle, then IDLE.
  - flush_done outside FLUSHING is ignored.
- Simultaneous out_ready and a new grant: the stage is overwritten in the same cycle with no bubble.
- Output stability: out_src and out_addr hold stable while out_valid && !out_ready.
- Reset mid-flush or mid-handshake: everything returns to reset values; a held output is discarded.

Decomposition:
- Shared package l2_arb_pkg holds:
  - src_t enum: SRC_RSP, SRC_FWD, SRC_FLUSH, SRC_CPU.
  - flush_state_t enum: IDLE, FLUSHING, DRAIN.
  - STARVE_LIMIT default constant.
- One natural sub-module, l2_arb_out_stage: the one-entry valid/ready register holding src and addr.

Test Plan:
- All four channels valid and the stage empty, cycle 0 → rsp_in_ready=1 only; cycle 1 out_valid=1, out_src=0. With rsp dropped, the next grants are fwd, then flush.
- fwd_in_valid=1 with fwd_stall=1, cpu_req_valid=1, mshr_full=0 → cpu granted, out_src=3, out_addr=cpu_req_addr.
- fwd_in_valid held high continuously with cpu_req_valid=1, STARVE_LIMIT=8 → cpu loses 8 grants, 9th grant goes to cpu, counter reads 0 afterward.
- Flush granted, then cpu_req_valid=1 for 20 cycles → cpu_req_ready=0 throughout, flushing=1. flush_done pulse → DRAIN for 1 cycle, then cpu granted on the next arbitration.
- out_ready=0 for 5 cycles with all inputs valid → all *_ready=0, out_addr stable. out_ready=1 → back-to-back grants, one per cycle.
- rst asserted while FLUSHING with out_valid=1 → next cycle out_valid=0, flushing=0, counter=0.
